turn_controller: RTL and testbench

- Front-end stage directly upstream of the game-state block: converts a raw push-button plus 4 square-select switches into clean, validated move requests.
- Drives that block's move/player/nextMove inputs and monitors its X_state/O_state/GameStatus outputs.
- Debounces the button, enforces turn alternation (X first) and rejects occupied or out-of-range squares before issuing anything.
- Halts input once the game is decided.

---
 rtl/turn_controller_pkg.sv | 34 +++
 rtl/turn_controller_button_debouncer.sv | 42 ++++
 rtl/turn_controller.sv | 107 ++++++++++
 tb/tb_turn_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/turn_controller_pkg.sv
// rtl/turn_controller_pkg.sv - shared encodings and board helpers for the turn controller
package turn_controller_pkg;

  localparam int BOARD_W = 9;

  localparam logic [2:0] ST_PLAY    = 3'd0;
  localparam logic [2:0] ST_XWIN    = 3'd1;
  localparam logic [2:0] ST_OWIN    = 3'd2;
  localparam logic [2:0] ST_DRAW    = 3'd3;
  localparam logic [2:0] ST_INVALID = 3'd4;

  localparam logic PLAYER_X = 1'b1;
  localparam logic PLAYER_O = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_OVER     = 3'd4
  } state_t;

  function automatic logic is_decided(input logic [2:0] status);
    return (status == ST_XWIN) || (status == ST_OWIN) || (status == ST_DRAW);
  endfunction

  // Out-of-range indices read as empty so callers need no separate guard.
  function automatic logic board_bit(input logic [BOARD_W-1:0] board, input logic [3:0] idx);
    logic [BOARD_W-1:0] shifted;
    shifted = board >> idx;
    return (idx < 4'd9) ? shifted[0] : 1'b0;
  endfunction

endpackage

// File: rtl/turn_controller_button_debouncer.sv
// rtl/turn_controller_button_debouncer.sv - synchronizer, stability counter and press pulse
module button_debouncer #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  logic        sync1;
  logic        sync2;
  logic        level;
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= 16'd0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= 1'b0;
      // Any sample agreeing with the current level restarts the count.
      if (sync2 != level) begin
        if (cnt >= DEB_CYCLES - 16'd1) begin
          level <= sync2;
          cnt   <= 16'd0;
          press <= sync2;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end else begin
        cnt <= 16'd0;
      end
    end
  end

endmodule

// File: rtl/turn_controller.sv
// rtl/turn_controller.sv - turns a debounced button plus square switches into validated move requests
module turn_controller
  import turn_controller_pkg::*;
#(
  parameter logic [15:0] DEB_CYCLES  = 16'd50000,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_move,
  input  logic [3:0]         sw_square,
  input  logic [BOARD_W-1:0] X_state,
  input  logic [BOARD_W-1:0] O_state,
  input  logic [2:0]         GameStatus,
  output logic               move,
  output logic               player,
  output logic [3:0]         nextMove,
  output logic               reject,
  output logic               ack_err,
  output logic               busy
);

  state_t             state;
  state_t             state_nxt;
  logic               press;
  logic [BOARD_W-1:0] occ;
  logic               sq_bad;
  logic               acked;
  logic               invalid;
  logic               decided;
  logic               tmo_hit;
  logic               reject_nxt;
  logic [7:0]         tmo_cnt;

  button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_debouncer (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_move),
    .press   (press)
  );

  assign occ     = X_state | O_state;
  assign sq_bad  = (nextMove > 4'd8) || board_bit(occ, nextMove);
  assign acked   = (player == PLAYER_X) ? board_bit(X_state, nextMove)
                                        : board_bit(O_state, nextMove);
  assign invalid = (GameStatus == ST_INVALID);
  assign decided = is_decided(GameStatus);
  assign tmo_hit = (tmo_cnt >= ACK_TIMEOUT - 8'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (decided)    state_nxt = S_OVER;
        else if (press) state_nxt = S_CHECK;
      end
      S_CHECK:    state_nxt = sq_bad ? S_IDLE : S_ISSUE;
      S_ISSUE:    state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: if (acked || invalid || tmo_hit) state_nxt = S_IDLE;
      S_OVER:     if (GameStatus == ST_PLAY) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // An acknowledgement seen in the same cycle as an invalid status still counts.
  always_comb begin
    move       = (state == S_ISSUE);
    busy       = (state == S_CHECK) || (state == S_ISSUE) || (state == S_WAIT_ACK);
    reject_nxt = 1'b0;
    case (state)
      S_IDLE:     reject_nxt = decided && press;
      S_CHECK:    reject_nxt = sq_bad;
      S_WAIT_ACK: reject_nxt = !acked && invalid;
      S_OVER:     reject_nxt = press;
      default:    reject_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      player   <= PLAYER_X;
      nextMove <= 4'd0;
      reject   <= 1'b0;
      ack_err  <= 1'b0;
      tmo_cnt  <= 8'd0;
    end else begin
      reject <= reject_nxt;
      case (state)
        S_IDLE:  if (!decided && press) nextMove <= sw_square;
        S_ISSUE: tmo_cnt <= 8'd0;
        S_WAIT_ACK: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (acked)                      player  <= ~player;
          else if (!invalid && tmo_hit)   ack_err <= 1'b1;
        end
        S_OVER:  if (GameStatus == ST_PLAY) player <= PLAYER_X;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_controller.sv
// tb/tb_turn_controller.sv - directed bench with a move-rule model and a per-cycle monitor
module tb_turn_controller;
  import turn_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_move = 1'b0;
  logic [3:0] sw_square = 4'd0;
  logic [8:0] x_board = 9'd0;
  logic [8:0] o_board = 9'd0;
  logic [2:0] game_status = ST_PLAY;
  logic       move, player, reject, ack_err, busy;
  logic [3:0] nextMove;

  turn_controller #(.DEB_CYCLES(16'd4), .ACK_TIMEOUT(8'd16)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_move   (btn_move),
    .sw_square  (sw_square),
    .X_state    (x_board),
    .O_state    (o_board),
    .GameStatus (game_status),
    .move       (move),
    .player     (player),
    .nextMove   (nextMove),
    .reject     (reject),
    .ack_err    (ack_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  int   seen_moves = 0;
  int   seen_rejects = 0;
  int   exp_moves = 0;
  int   exp_rejects = 0;
  bit   resp_en = 1'b1;
  bit   model_over = 1'b0;
  bit   model_ack_err = 1'b0;
  bit   wait_expired = 1'b0;
  logic model_player = 1'b1;
  logic exp_player = 1'b1;
  logic [3:0] exp_sq = 4'd0;
  logic prev_move = 1'b0;
  bit   load_req = 1'b0;
  logic [8:0] ld_x = 9'd0;
  logic [8:0] ld_o = 9'd0;
  int   ckpt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Single checking process: per-cycle move monitor, board responder and checkpoints.
  always @(negedge clk) begin
    if (rst) begin
      if (move) begin
        seen_moves++;
        chk("move_expected", int'(seen_moves <= exp_moves), 1);
        chk("move_player", int'(player), int'(exp_player));
        chk("move_square", int'(nextMove), int'(exp_sq));
        chk("move_single", int'(prev_move), 0);
        if (resp_en) begin
          if (player) x_board = x_board | (9'd1 << nextMove);
          else        o_board = o_board | (9'd1 << nextMove);
        end
      end
      if (reject) seen_rejects++;
    end
    prev_move = move;
    if (load_req) begin
      x_board = ld_x;
      o_board = ld_o;
    end
    case (ckpt)
      1: begin
        chk("rst_move", int'(move), 0);
        chk("rst_player", int'(player), 1);
        chk("rst_next_move", int'(nextMove), 0);
        chk("rst_reject", int'(reject), 0);
        chk("rst_ack_err", int'(ack_err), 0);
        chk("rst_busy", int'(busy), 0);
      end
      2: begin
        chk("move_count", seen_moves, exp_moves);
        chk("reject_count", seen_rejects, exp_rejects);
        chk("player", int'(player), int'(model_player));
        chk("ack_err", int'(ack_err), int'(model_ack_err));
        chk("idle_busy", int'(busy), 0);
        chk("wait_bound", int'(wait_expired), 0);
      end
      3: begin
        chk("first_player", int'(player), 0);
        chk("first_x_board", int'(x_board), 1);
        chk("first_next_move", int'(nextMove), 0);
      end
      4: begin
        chk("timeout_ack_err", int'(ack_err), 1);
        chk("timeout_player", int'(player), 0);
      end
      5: chk("over_return_player", int'(player), 1);
      6: chk("inflight_busy", int'(busy), 1);
      default: ;
    endcase
  end

  task automatic cp(input int id);
    ckpt = id;
    @(negedge clk);
    #1 ckpt = 0;
  endtask

  task automatic load(input logic [8:0] xb, input logic [8:0] ob);
    ld_x = xb;
    ld_o = ob;
    load_req = 1'b1;
    @(negedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic press(input logic [3:0] sq, input bit bounce);
    bit ok;
    int t;
    logic [8:0] occ_shift;
    occ_shift = (x_board | o_board) >> sq;
    ok = !model_over && (sq <= 4'd8) && !occ_shift[0];
    if (ok) begin
      exp_player = model_player;
      exp_sq = sq;
      exp_moves++;
    end else begin
      exp_rejects++;
    end
    @(posedge clk);
    sw_square = sq;
    if (bounce) begin
      for (int i = 0; i < 4; i++) begin
        btn_move = (i % 2 == 0);
        @(posedge clk);
      end
    end
    btn_move = 1'b1;
    repeat (10) @(posedge clk);
    btn_move = 1'b0;
    sw_square = 4'd7;
    repeat (10) @(posedge clk);
    t = 0;
    @(negedge clk);
    while (busy && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (busy) wait_expired = 1'b1;
    repeat (3) @(posedge clk);
    if (ok) begin
      if (resp_en) model_player = ~model_player;
      else         model_ack_err = 1'b1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    cp(1);
    @(posedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    press(4'd0, 1'b0);
    cp(2);
    cp(3);
    press(4'd1, 1'b1);
    cp(2);

    load(9'b000_010_000, 9'd0);
    press(4'd4, 1'b0);
    cp(2);
    press(4'd9, 1'b0);
    cp(2);
    press(4'd8, 1'b0);
    cp(2);

    resp_en = 1'b0;
    press(4'd0, 1'b0);
    cp(2);
    cp(4);
    resp_en = 1'b1;

    press(4'd2, 1'b0);
    cp(2);
    press(4'd3, 1'b0);
    cp(2);
    game_status = ST_XWIN;
    model_over = 1'b1;
    repeat (3) @(posedge clk);
    press(4'd5, 1'b0);
    cp(2);
    game_status = ST_PLAY;
    model_over = 1'b0;
    model_player = 1'b1;
    repeat (3) @(posedge clk);
    cp(2);
    cp(5);
    press(4'd5, 1'b0);
    cp(2);

    resp_en = 1'b0;
    exp_player = model_player;
    exp_sq = 4'd6;
    exp_moves++;
    @(posedge clk);
    sw_square = 4'd6;
    btn_move = 1'b1;
    repeat (10) @(posedge clk);
    cp(6);
    rst = 1'b0;
    btn_move = 1'b0;
    #1;
    cp(1);
    model_player = 1'b1;
    model_ack_err = 1'b0;
    @(posedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    cp(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
